imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 125 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage feeding a 2-entry in-order skid buffer.
// Handles sign/zero/upper/branch-offset modes; in_ready is registered so it never depends on out_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   return sext;
      2'b01:   return {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   return {imm, {(OUT_W-IN_W){1'b0}}};
      default: return {sext[OUT_W-3:0], 2'b00};
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic [OUT_W-1:0] new_data;
  logic             in_xfer;
  logic             out_xfer;

  assign new_data  = extend(in_imm, in_mode);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data_d = new_data;
            out_tag_d  = in_tag;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data_d = new_data;
            out_tag_d  = in_tag;
          end else if (in_xfer) begin
            skid_data_d = new_data;
            skid_tag_d  = in_tag;
            state_d     = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            out_data_d = skid_data_q;
            out_tag_d  = skid_tag_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: fixed vectors, hand-written handshake corner cases,
// and a randomized run against a queue-based reference model.
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } item_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference extension from plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'b00:   return 32'(s);
      2'b01:   return 32'(imm);
      2'b10:   return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic fill_two(input logic [4:0] t0, input logic [4:0] t1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_imm    = 16'h0100;
    in_tag    = t0;
    step();
    in_imm = 16'h0200;
    in_tag = t1;
    step();
    in_valid = 1'b0;
  endtask

  vec_t  vecs[12];
  item_t model_q[$];

  initial begin
    vecs[0]  = '{2'b00, 16'h0014, 32'h0000_0014};
    vecs[1]  = '{2'b00, 16'hFF92, 32'hFFFF_FF92};
    vecs[2]  = '{2'b01, 16'hFF92, 32'h0000_FF92};
    vecs[3]  = '{2'b10, 16'h1234, 32'h1234_0000};
    vecs[4]  = '{2'b11, 16'hFFFF, 32'hFFFF_FFFC};
    vecs[5]  = '{2'b11, 16'h7FFF, 32'h0001_FFFC};
    vecs[6]  = '{2'b00, 16'h8000, 32'hFFFF_8000};
    vecs[7]  = '{2'b01, 16'h8000, 32'h0000_8000};
    vecs[8]  = '{2'b10, 16'hFFFF, 32'hFFFF_0000};
    vecs[9]  = '{2'b11, 16'h8000, 32'hFFFE_0000};
    vecs[10] = '{2'b11, 16'h0001, 32'h0000_0004};
    vecs[11] = '{2'b00, 16'h7FFF, 32'h0000_7FFF};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'b00;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset occupancy", 64'(occupancy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Vector table, streamed back-to-back with out_ready high; each result 1 cycle after its input.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_mode  = vecs[i].mode;
      in_imm   = vecs[i].imm;
      in_tag   = 5'(i);
      step();
      check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d data", i), 64'(out_data), 64'(vecs[i].exp));
      check($sformatf("vec%0d tag", i), 64'(out_tag), 64'(i));
    end
    in_valid = 1'b0;
    step();
    check("drain empty", 64'(out_valid), 64'd0);

    // Backpressure with three back-to-back inputs.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    for (int t = 1; t <= 3; t++) begin
      in_tag = 5'(t);
      in_imm = 16'(t * 16);
      step();
    end
    check("bp occupancy", 64'(occupancy), 64'd2);
    check("bp in_ready", 64'(in_ready), 64'd0);
    check("bp head tag", 64'(out_tag), 64'd1);
    step();
    check("bp stable tag", 64'(out_tag), 64'd1);
    check("bp stable data", 64'(out_data), 64'h10);
    out_ready = 1'b1;
    #1;
    check("bp out1 tag", 64'(out_tag), 64'd1);
    step();
    check("bp out2 valid", 64'(out_valid), 64'd1);
    check("bp out2 tag", 64'(out_tag), 64'd2);
    step();
    in_valid = 1'b0;
    check("bp out3 valid", 64'(out_valid), 64'd1);
    check("bp out3 tag", 64'(out_tag), 64'd3);
    check("bp out3 data", 64'(out_data), 64'h30);
    step();
    check("bp drained", 64'(out_valid), 64'd0);

    // Streaming: occupancy must never exceed one.
    in_valid = 1'b1;
    in_mode  = 2'b00;
    for (int i = 0; i < 10; i++) begin
      in_tag = 5'(i + 10);
      in_imm = 16'(i);
      step();
      check($sformatf("stream%0d tag", i), 64'(out_tag), 64'(i + 10));
      check($sformatf("stream%0d occ", i), 64'(occupancy <= 2'd1), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 64'(out_valid), 64'd0);

    // Flush in TWO with a simultaneous input.
    fill_two(5'd20, 5'd21);
    check("pre-flush occ", 64'(occupancy), 64'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 5'd22;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush occupancy", 64'(occupancy), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-flush idle", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset between edges in TWO.
    fill_two(5'd24, 5'd25);
    #2;
    reset = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst occupancy", 64'(occupancy), 64'd0);
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst out_tag", 64'(out_tag), 64'd0);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b11;
    in_imm    = 16'hFFFF;
    in_tag    = 5'd26;
    step();
    in_valid = 1'b0;
    check("after rst valid", 64'(out_valid), 64'd1);
    check("after rst data", 64'(out_data), 64'hFFFF_FFFC);
    check("after rst tag", 64'(out_tag), 64'd26);
    step();
    check("after rst no stale", 64'(out_valid), 64'd0);

    // Randomized run against the queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic ox;
      logic ix;
      item_t it;
      check("rnd occupancy", 64'(occupancy), 64'(model_q.size()));
      check("rnd in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      check("rnd out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("rnd out_data", 64'(out_data), 64'(model_q[0].data));
        check("rnd out_tag", 64'(out_tag), 64'(model_q[0].tag));
      end
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 40) == 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      if (flush) begin
        model_q.delete();
      end else begin
        ox = (model_q.size() != 0) && out_ready;
        ix = in_valid && (model_q.size() < 2);
        if (ox) void'(model_q.pop_front());
        if (ix) begin
          it.data = ref_ext(in_imm, in_mode);
          it.tag  = in_tag;
          model_q.push_back(it);
        end
      end
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
